// File: rtl/stackcalc_pkg.sv
// Shared types and io_in bit layout for the stackcalc sequencer.
package stackcalc_pkg;

    localparam int unsigned IO_W     = 8;
    localparam int unsigned MODE_W   = 2;
    localparam int unsigned DATA_W   = 4;

    localparam int unsigned CLK_BIT  = 0;
    localparam int unsigned RST_BIT  = 1;
    localparam int unsigned DATA_LSB = 2;
    localparam int unsigned MODE_LSB = 6;

    typedef enum logic [2:0] {
        CRST,
        IDLE,
        SETUP,
        HIGH,
        LOW,
        CAPT
    } state_t;

    typedef struct packed {
        logic [MODE_W-1:0] mode;
        logic [DATA_W-1:0] data;
        logic              rd;
    } cmd_t;

endpackage

// File: rtl/stackcalc_sequencer_if.sv
// Host-side command and result handshakes of the stackcalc sequencer.
interface stackcalc_sequencer_if;
    import stackcalc_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [MODE_W-1:0] cmd_mode;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_rd;

    logic              res_valid;
    logic              res_ready;
    logic [IO_W-1:0]   res_data;

    modport master (
        output cmd_valid, cmd_mode, cmd_data, cmd_rd, res_ready,
        input  cmd_ready, res_valid, res_data
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_data, cmd_rd, res_ready,
        output cmd_ready, res_valid, res_data
    );

endinterface

// File: rtl/stackcalc_cmd_fifo.sv
// Synchronous command FIFO with occupancy output; head is read combinationally.
module stackcalc_cmd_fifo
    import stackcalc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  cmd_t                     din,
    output cmd_t                     head_c,
    output logic                     full_c,
    output logic                     empty_c,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head_c  = mem[rd_ptr];
    assign full_c  = (level == LVL_W'(DEPTH));
    assign empty_c = (level == '0);

    // Storage write; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-2 depth; level tracks push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/stackcalc_sequencer.sv
// Sequences the stackcalc io_in bus (clock, reset, mode, data) from queued commands
// and captures io_out into a result register on request.
module stackcalc_sequencer
    import stackcalc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned HIGH_CYC   = 2,
    parameter int unsigned LOW_CYC    = 2,
    parameter int unsigned RST_CYC    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    stackcalc_sequencer_if.slave          bus,
    input  logic                          calc_rst_req,
    output logic [IO_W-1:0]               calc_io_in,
    input  logic [IO_W-1:0]               calc_io_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned CNT_MAX = (SETUP_CYC > HIGH_CYC)
        ? ((SETUP_CYC > LOW_CYC) ? SETUP_CYC : LOW_CYC)
        : ((HIGH_CYC  > LOW_CYC) ? HIGH_CYC  : LOW_CYC);
    localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned PLS_W = $clog2(RST_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HIGH_LD  = CNT_W'(HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LOW_LD   = CNT_W'(LOW_CYC - 1);
    localparam logic [IO_W-1:0]  IO_RESET = IO_W'(1 << RST_BIT);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [PLS_W-1:0] pulses, pulses_n;
    logic             crst_hi, crst_hi_n;
    logic             rst_pend;
    cmd_t             cmd_q;
    cmd_t             cmd_in_c;
    cmd_t             head_c;
    logic             fifo_full_c;
    logic             fifo_empty_c;
    logic             push_c;
    logic             pop_c;
    logic             capt_c;
    logic             slot_free_c;
    logic [IO_W-1:0]  io_n;
    logic             res_valid_q;
    logic [IO_W-1:0]  res_data_q;

    assign cmd_in_c      = {bus.cmd_mode, bus.cmd_data, bus.cmd_rd};
    assign bus.cmd_ready = !fifo_full_c && (state != CRST);
    assign push_c        = bus.cmd_valid && bus.cmd_ready;
    assign slot_free_c   = !res_valid_q || bus.res_ready;
    assign busy          = (state != IDLE) || !fifo_empty_c;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;

    stackcalc_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_c),
        .pop     (pop_c),
        .din     (cmd_in_c),
        .head_c  (head_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c),
        .level   (fifo_level)
    );

    // Next state, shared phase counter and the io_in value for the next cycle.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pulses_n  = pulses;
        crst_hi_n = crst_hi;
        pop_c     = 1'b0;
        capt_c    = 1'b0;
        io_n      = '0;
        case (state)
            CRST: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else if (crst_hi) begin
                    crst_hi_n = 1'b0;
                    cnt_n     = LOW_LD;
                end else if (pulses == PLS_W'(RST_CYC)) begin
                    state_n = IDLE;
                end else begin
                    crst_hi_n = 1'b1;
                    cnt_n     = HIGH_LD;
                    pulses_n  = pulses + PLS_W'(1);
                end
            end
            IDLE: begin
                if (rst_pend) begin
                    state_n   = CRST;
                    crst_hi_n = 1'b0;
                    cnt_n     = LOW_LD;
                    pulses_n  = '0;
                end else if (!fifo_empty_c) begin
                    pop_c   = 1'b1;
                    state_n = SETUP;
                    cnt_n   = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    state_n = HIGH;
                    cnt_n   = HIGH_LD;
                end
            end
            HIGH: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    state_n = LOW;
                    cnt_n   = LOW_LD;
                end
            end
            LOW: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else if (!cmd_q.rd) begin
                    state_n = IDLE;
                end else if (slot_free_c) begin
                    // Capture on the last low cycle when the result slot is free.
                    capt_c  = 1'b1;
                    state_n = IDLE;
                end else begin
                    state_n = CAPT;
                end
            end
            CAPT: begin
                if (slot_free_c) begin
                    capt_c  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = CRST;
            end
        endcase
        io_n[CLK_BIT]              = (state_n == HIGH) || ((state_n == CRST) && crst_hi_n);
        io_n[RST_BIT]              = (state_n == CRST);
        io_n[DATA_LSB +: DATA_W]   = pop_c ? head_c.data : cmd_q.data;
        io_n[MODE_LSB +: MODE_W]   = pop_c ? head_c.mode : cmd_q.mode;
    end

    // State, counters, command register and registered io_in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CRST;
            cnt        <= LOW_LD;
            pulses     <= '0;
            crst_hi    <= 1'b0;
            cmd_q      <= '0;
            calc_io_in <= IO_RESET;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            pulses     <= pulses_n;
            crst_hi    <= crst_hi_n;
            calc_io_in <= io_n;
            if (pop_c) cmd_q <= head_c;
        end
    end

    // Reset request flag; requests arriving while a reset sequence runs are absorbed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_pend <= 1'b0;
        end else if ((state == CRST) || (state_n == CRST)) begin
            rst_pend <= 1'b0;
        end else if (calc_rst_req) begin
            rst_pend <= 1'b1;
        end
    end

    // Result register; a drain and a new capture may coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else if (capt_c) begin
            res_valid_q <= 1'b1;
            res_data_q  <= calc_io_out;
        end else if (bus.res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

endmodule
